codec_audio_edge_pio: RTL and testbench

CODEC_AUDIO_EDGE_PIO -- requirements
Module: codec_audio_edge_pio

---
 rtl/codec_audio_edge_pio.sv | 143 ++++++++++++++
 tb/tb_codec_audio_edge_pio.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/codec_audio_edge_pio.sv
// Debounced parallel input port with per-bit rise/fall edge capture and a masked level IRQ.
// Inputs are synchronised, debounced, edge-detected, then latched until software clears them.
module codec_audio_edge_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit BIT_CLEAR       = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_RISE  = 3'd1;
  localparam logic [2:0] ADDR_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE  = 3'd3;
  localparam logic [2:0] ADDR_FALL  = 3'd4;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [CW-1:0]    cnt [WIDTH];

  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_next;
  logic [31:0]      rd_next;

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  assign wr    = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // A mismatch must persist for DEBOUNCE_CYCLES samples; any agreement restarts the count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset) begin
        cnt[i]    <= '0;
        stable[i] <= 1'b0;
      end else if (s2[i] == stable[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_LAST) begin
        cnt[i]    <= '0;
        stable[i] <= s2[i];
      end else begin
        cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  always_comb begin
    edge_set = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en);
    edge_clr = '0;
    if (wr && address == ADDR_EDGE) begin
      edge_clr = BIT_CLEAR ? wdata : '1;
    end
    // Set is OR-ed in after the clear so a same-cycle edge is never lost.
    edge_next = (edge_capture & ~edge_clr) | edge_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= edge_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_en  <= '0;
      irq_mask <= '0;
      fall_en  <= '1;
    end else if (wr) begin
      if (address == ADDR_RISE) rise_en  <= wdata;
      if (address == ADDR_MASK) irq_mask <= wdata;
      if (address == ADDR_FALL) fall_en  <= wdata;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[WIDTH-1:0] = stable;
      ADDR_RISE: rd_next[WIDTH-1:0] = rise_en;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
      ADDR_FALL: rd_next[WIDTH-1:0] = fall_en;
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_codec_audio_edge_pio.sv
// Bench for codec_audio_edge_pio: register table, timed corner sequences, and random
// traffic compared cycle by cycle against a run-length behavioural model.
module tb_codec_audio_edge_pio;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata, readdata_b;
  logic        irq, irq_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  codec_audio_edge_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .BIT_CLEAR(1'b1)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq));

  codec_audio_edge_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .BIT_CLEAR(1'b0)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_b), .irq(irq_b));

  // Behavioural model: s2 is the input two samples late; a bit flips once s2 has
  // disagreed with the accepted level for DEB consecutive samples.
  logic [3:0]  m_s1, m_s2, m_stable, m_prev, m_rise, m_fall, m_mask, m_ec;
  logic [31:0] m_rd;
  int          m_run [4];

  task automatic model_step(input logic r, input logic [2:0] a, input logic c,
                            input logic w, input logic [31:0] d, input logic [3:0] p);
    logic [3:0] set, clr;
    logic       wr;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_prev = 0; m_rise = 0; m_mask = 0;
      m_ec = 0; m_fall = 4'hF; m_rd = 0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
      return;
    end
    wr = c & ~w;
    case (a)
      3'd0: m_rd = {28'd0, m_stable};
      3'd1: m_rd = {28'd0, m_rise};
      3'd2: m_rd = {28'd0, m_mask};
      3'd3: m_rd = {28'd0, m_ec};
      3'd4: m_rd = {28'd0, m_fall};
      default: m_rd = 0;
    endcase
    set = 0;
    for (int b = 0; b < 4; b++) begin
      if (m_stable[b] && !m_prev[b] && m_rise[b]) set[b] = 1'b1;
      if (!m_stable[b] && m_prev[b] && m_fall[b]) set[b] = 1'b1;
    end
    clr = (wr && a == 3'd3) ? d[3:0] : 4'h0;
    m_ec = (m_ec & ~clr) | set;
    if (wr && a == 3'd1) m_rise = d[3:0];
    if (wr && a == 3'd2) m_mask = d[3:0];
    if (wr && a == 3'd4) m_fall = d[3:0];
    m_prev = m_stable;
    for (int b = 0; b < 4; b++) begin
      if (m_s2[b] != m_stable[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_stable[b] = m_s2[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = p;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, clock once, then compare at the next falling edge.
  task automatic step(input logic r, input logic [2:0] a, input logic c,
                      input logic w, input logic [31:0] d, input logic [3:0] p);
    reset = r; address = a; chipselect = c; write_n = w; writedata = d; in_port = p;
    @(posedge clk);
    model_step(r, a, c, w, d, p);
    @(negedge clk);
    check("model_readdata", readdata, m_rd);
    check("model_irq", {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
  endtask

  task automatic idle(input logic [3:0] p, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 1'b1, 32'd0, p);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] p);
    step(1'b0, a, 1'b1, 1'b0, d, p);
  endtask

  task automatic do_reset();
    step(1'b1, 3'd0, 1'b0, 1'b1, 32'd0, 4'h0);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [3:0] p;
    // readdata reflects the register value before the same edge's write
    vecs[0]  = '{3'd1, 1'b1, 1'b0, 32'h0000_0005, 32'h0};
    vecs[1]  = '{3'd1, 1'b0, 1'b1, 32'h0,         32'h5};
    vecs[2]  = '{3'd2, 1'b1, 1'b0, 32'hFFFF_FFF3, 32'h0};
    vecs[3]  = '{3'd2, 1'b0, 1'b1, 32'h0,         32'h3};
    vecs[4]  = '{3'd4, 1'b0, 1'b1, 32'h0,         32'hF};
    vecs[5]  = '{3'd4, 1'b0, 1'b0, 32'h6,         32'hF};
    vecs[6]  = '{3'd4, 1'b1, 1'b1, 32'h6,         32'hF};
    vecs[7]  = '{3'd4, 1'b1, 1'b0, 32'h9,         32'hF};
    vecs[8]  = '{3'd4, 1'b0, 1'b1, 32'h0,         32'h9};
    vecs[9]  = '{3'd5, 1'b1, 1'b0, 32'hF,         32'h0};
    vecs[10] = '{3'd5, 1'b0, 1'b1, 32'h0,         32'h0};
    vecs[11] = '{3'd7, 1'b0, 1'b1, 32'h0,         32'h0};
    vecs[12] = '{3'd3, 1'b0, 1'b1, 32'h0,         32'h0};
    vecs[13] = '{3'd0, 1'b0, 1'b1, 32'h0,         32'h0};
    vecs[14] = '{3'd1, 1'b0, 1'b1, 32'h0,         32'h5};

    reset = 1'b1; address = 0; chipselect = 0; write_n = 1; writedata = 0; in_port = 0;
    @(negedge clk);
    do_reset();
    do_reset();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    check("reset_edge_capture", {28'd0, dut.edge_capture}, 32'h0);

    for (int i = 0; i < 15; i++) begin
      step(1'b0, vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wd, 4'h0);
      check($sformatf("table_%0d", i), readdata, vecs[i].exp_rd);
    end

    // Rise latency: stable after edge k+5, capture after edge k+6
    do_reset();
    wr_reg(3'd1, 32'hF, 4'h0);
    wr_reg(3'd2, 32'h1, 4'h0);
    for (int i = 0; i <= 6; i++) begin
      idle(4'h1, 1);
      check($sformatf("rise_stable_k%0d", i), {28'd0, dut.stable}, (i >= 5) ? 32'h1 : 32'h0);
      check($sformatf("rise_capture_k%0d", i), {28'd0, dut.edge_capture}, (i >= 6) ? 32'h1 : 32'h0);
    end
    check("rise_irq", {31'd0, irq}, 32'h1);

    // Glitch of 3 samples is rejected
    do_reset();
    wr_reg(3'd1, 32'hF, 4'h0);
    wr_reg(3'd2, 32'hF, 4'h0);
    idle(4'h4, 3);
    idle(4'h0, 10);
    check("glitch_stable", {28'd0, dut.stable}, 32'h0);
    check("glitch_capture", {28'd0, dut.edge_capture}, 32'h0);
    check("glitch_irq", {31'd0, irq}, 32'h0);

    // Mask gating, then per-bit vs clear-all behaviour
    do_reset();
    wr_reg(3'd1, 32'h3, 4'h0);
    idle(4'h3, 8);
    check("mask0_capture", {28'd0, dut.edge_capture}, 32'h3);
    check("mask0_irq", {31'd0, irq}, 32'h0);
    wr_reg(3'd2, 32'h2, 4'h3);
    check("mask2_irq", {31'd0, irq}, 32'h1);
    check("mask2_capture_kept", {28'd0, dut.edge_capture}, 32'h3);
    check("clrall_pre", {28'd0, dut_b.edge_capture}, 32'h3);
    wr_reg(3'd3, 32'h1, 4'h3);
    check("w1c_capture", {28'd0, dut.edge_capture}, 32'h2);
    check("clrall_capture", {28'd0, dut_b.edge_capture}, 32'h0);
    check("w1c_irq", {31'd0, irq}, 32'h1);
    step(1'b0, 3'd3, 1'b0, 1'b1, 32'h0, 4'h3);
    check("w1c_readback", readdata, 32'h2);

    // Edge detected in the same cycle as its clear: set wins
    do_reset();
    wr_reg(3'd1, 32'hF, 4'h0);
    idle(4'h2, 6);
    check("setwin_pre_stable", {28'd0, dut.stable}, 32'h2);
    check("setwin_pre_capture", {28'd0, dut.edge_capture}, 32'h0);
    wr_reg(3'd3, 32'h2, 4'h2);
    check("setwin_capture", {28'd0, dut.edge_capture}, 32'h2);
    check("setwin_capture_clrall", {28'd0, dut_b.edge_capture}, 32'h2);

    // Fall-only on bit 3, then a single reset cycle
    do_reset();
    wr_reg(3'd4, 32'h8, 4'h0);
    idle(4'h8, 8);
    check("fall_rise_ignored", {28'd0, dut.edge_capture}, 32'h0);
    idle(4'h0, 8);
    check("fall_captured", {28'd0, dut.edge_capture}, 32'h8);
    wr_reg(3'd2, 32'hF, 4'h0);
    check("fall_irq", {31'd0, irq}, 32'h1);
    do_reset();
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    step(1'b0, 3'd4, 1'b0, 1'b1, 32'h0, 4'h0);
    check("rst_fall_en", readdata, 32'hF);
    step(1'b0, 3'd3, 1'b0, 1'b1, 32'h0, 4'h0);
    check("rst_edge_capture", readdata, 32'h0);
    step(1'b0, 3'd2, 1'b0, 1'b1, 32'h0, 4'h0);
    check("rst_irq_mask", readdata, 32'h0);
    step(1'b0, 3'd1, 1'b0, 1'b1, 32'h0, 4'h0);
    check("rst_rise_en", readdata, 32'h0);

    // Random traffic against the model
    p = 4'h0;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) p[b] = ~p[b];
      step(($urandom_range(0, 199) == 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           $urandom, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
